branch_resolve: RTL and testbench

Pipelined, parametrised branch resolution stage for the execute pipe. It accepts one branch or jump per cycle through a valid/ready handshake and evaluates the condition for the configured data width. It computes the target, compares outcome and target against the front-end prediction, and emits a registered redirect record through a 2-entry skid buffer. It also keeps saturating branch and mispredict counters for performance monitoring.

---
 rtl/control_pkg.sv | 31 +++
 rtl/branch_resolve_if.sv | 41 ++++
 rtl/brc_skid.sv | 64 ++++++
 rtl/branch_resolve.sv | 106 ++++++++++
 tb/tb_branch_resolve.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/control_pkg.sv
// control_pkg: shared control-path types for the execute pipe.
//   branch_type_e : condition select for branch/jump instructions.
//   redirect_t    : redirect record produced by branch resolution.
//   PC_STEP       : sequential PC increment.
// Packages cannot take parameters, so the redirect record carries a PC field
// of XLEN_MAX bits; an XLEN=32 instance zero-extends into it and uses the low half.
package control_pkg;

    typedef enum logic [3:0] {
        BR_NONE   = 4'd0,
        BR_EQ     = 4'd1,
        BR_NE     = 4'd2,
        BR_LT     = 4'd3,
        BR_GE     = 4'd4,
        BR_LTU    = 4'd5,
        BR_GEU    = 4'd6,
        BR_UNCOND = 4'd7
    } branch_type_e;

    localparam int XLEN_MAX = 64;
    localparam int PC_STEP  = 4;

    typedef struct packed {
        logic                taken;
        logic [XLEN_MAX-1:0] next_pc;
        logic                mispredict;
        logic                misaligned;
        logic                is_branch;
    } redirect_t;

endpackage

// File: rtl/branch_resolve_if.sv
// branch_resolve_if: request/result handshake bundle for branch_resolve.
//   in_*  : branch request (valid/ready), driven by the issue side.
//   out_* : redirect result (valid/ready), consumed by the front end.
// Modports: master = issue/consumer side, slave = branch_resolve.
interface branch_resolve_if
    import control_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    branch_type_e    in_branch_type;
    logic            in_is_jalr;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [XLEN-1:0] in_imm;
    logic            in_pred_taken;
    logic [XLEN-1:0] in_pred_target;

    logic            out_valid;
    logic            out_ready;
    logic            out_taken;
    logic [XLEN-1:0] out_next_pc;
    logic            out_mispredict;
    logic            out_misaligned;

    modport master (
        output in_valid, in_branch_type, in_is_jalr, in_pc, in_rs1, in_rs2,
               in_imm, in_pred_taken, in_pred_target, out_ready,
        input  in_ready, out_valid, out_taken, out_next_pc, out_mispredict,
               out_misaligned
    );

    modport slave (
        input  in_valid, in_branch_type, in_is_jalr, in_pc, in_rs1, in_rs2,
               in_imm, in_pred_taken, in_pred_target, out_ready,
        output in_ready, out_valid, out_taken, out_next_pc, out_mispredict,
               out_misaligned
    );
endinterface

// File: rtl/brc_skid.sv
// brc_skid: generic 2-entry valid/ready skid buffer (main + skid register).
//   clk, rst_n          : clock, async active-low reset.
//   flush               : drops both held entries and any incoming one.
//   in_valid/in_ready   : upstream handshake; in_ready depends only on state.
//   in_data             : W-bit payload.
//   out_valid/out_ready : downstream handshake, out_data = main register.
module brc_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         main_valid;
    logic         skid_valid;
    logic [W-1:0] main_data;
    logic [W-1:0] skid_data;
    logic         accept;
    logic         main_free;

    // Ready comes from a register only, so downstream ready never ripples upstream.
    assign in_ready  = !skid_valid;
    assign accept    = in_valid && in_ready && !flush;
    assign main_free = !main_valid || out_ready;

    // NOTE: payload registers are reset as well because the output record
    // must read as all-zero out of reset, not just be qualified by valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            // NOTE: non-blocking assignments let main read the old skid value
            // in the same edge skid is cleared, independent of statement order.
            if (skid_valid) begin
                main_data  <= skid_data;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_data  <= in_data;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid = main_valid;
    assign out_data  = main_data;
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: execute-pipe branch resolution stage.
//   clk, rst_n      : clock, async active-low reset.
//   bus (slave)     : request in, redirect record out (valid/ready both sides).
//   flush           : kills held and incoming entries.
//   cnt_clr         : synchronous clear of both performance counters.
//   cnt_branches    : saturating count of resolved branches (BR_NONE excluded).
//   cnt_mispredicts : saturating count of resolved mispredicts.
module branch_resolve
    import control_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    branch_resolve_if.slave  bus,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_branches,
    output logic [CNT_W-1:0] cnt_mispredicts
);
    logic            taken;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] next_pc;
    redirect_t       rec_in;
    redirect_t       rec_out;
    logic            count_en;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        taken = 1'b0;
        case (bus.in_branch_type)
            BR_EQ:     taken = (bus.in_rs1 == bus.in_rs2);
            BR_NE:     taken = (bus.in_rs1 != bus.in_rs2);
            BR_LT:     taken = ($signed(bus.in_rs1) <  $signed(bus.in_rs2));
            BR_GE:     taken = ($signed(bus.in_rs1) >= $signed(bus.in_rs2));
            BR_LTU:    taken = (bus.in_rs1 <  bus.in_rs2);
            BR_GEU:    taken = (bus.in_rs1 >= bus.in_rs2);
            BR_UNCOND: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

    // Jump-register targets drop bit 0; all sums wrap modulo 2^XLEN.
    assign sum     = (bus.in_is_jalr ? bus.in_rs1 : bus.in_pc) + bus.in_imm;
    assign target  = bus.in_is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;
    assign seq_pc  = bus.in_pc + XLEN'(PC_STEP);
    assign next_pc = taken ? target : seq_pc;

    always_comb begin
        rec_in            = '0;
        rec_in.taken      = taken;
        rec_in.next_pc    = XLEN_MAX'(next_pc);
        rec_in.mispredict = (taken != bus.in_pred_taken) ||
                            (taken && bus.in_pred_taken && (target != bus.in_pred_target));
        rec_in.misaligned = taken && target[1];
        rec_in.is_branch  = (bus.in_branch_type != BR_NONE);
    end

    brc_skid #(
        .W($bits(redirect_t))
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (rec_in),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (rec_out)
    );

    assign bus.out_taken      = rec_out.taken;
    assign bus.out_next_pc    = rec_out.next_pc[XLEN-1:0];
    assign bus.out_mispredict = rec_out.mispredict;
    assign bus.out_misaligned = rec_out.misaligned;

    // Upper PC bits of the shared record are always zero for narrow instances.
    if (XLEN < XLEN_MAX) begin : g_pc_hi
        logic unused_pc_hi;
        assign unused_pc_hi = |rec_out.next_pc[XLEN_MAX-1:XLEN];
    end

    assign count_en = bus.out_valid && bus.out_ready && rec_out.is_branch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_branches    <= '0;
            cnt_mispredicts <= '0;
        end else if (cnt_clr) begin
            cnt_branches    <= '0;
            cnt_mispredicts <= '0;
        end else if (count_en) begin
            if (cnt_branches != '1) begin
                cnt_branches <= cnt_branches + 1'b1;
            end
            if (rec_out.mispredict && (cnt_mispredicts != '1)) begin
                cnt_mispredicts <= cnt_mispredicts + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed self-checking bench for branch_resolve
// (XLEN=32, CNT_W=4). Inputs change 1 ns after the rising edge; outputs
// are compared at that same point, well away from the next edge.
module tb_branch_resolve;
    import control_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       cnt_clr;
    logic [3:0] cnt_branches;
    logic [3:0] cnt_mispredicts;
    int         checks;
    int         errors;

    branch_resolve_if #(.XLEN(32)) bus ();

    branch_resolve #(
        .XLEN  (32),
        .CNT_W (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .flush           (flush),
        .cnt_clr         (cnt_clr),
        .cnt_branches    (cnt_branches),
        .cnt_mispredicts (cnt_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input branch_type_e t, input logic jalr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                         input logic pt, input logic [31:0] ptgt);
        bus.in_valid       = 1'b1;
        bus.in_branch_type = t;
        bus.in_is_jalr     = jalr;
        bus.in_pc          = pc;
        bus.in_rs1         = rs1;
        bus.in_rs2         = rs2;
        bus.in_imm         = imm;
        bus.in_pred_taken  = pt;
        bus.in_pred_target = ptgt;
    endtask

    task automatic check_out(input string tag, input logic tk, input logic [31:0] npc,
                             input logic mp, input logic mis);
        check({tag, ".valid"},      64'(bus.out_valid),      64'd1);
        check({tag, ".taken"},      64'(bus.out_taken),      64'(tk));
        check({tag, ".next_pc"},    64'(bus.out_next_pc),    64'(npc));
        check({tag, ".mispredict"}, 64'(bus.out_mispredict), 64'(mp));
        check({tag, ".misaligned"}, 64'(bus.out_misaligned), 64'(mis));
    endtask

    task automatic check_cnt(input string tag, input logic [3:0] br, input logic [3:0] mp);
        check({tag, ".cnt_branches"},    64'(cnt_branches),    64'(br));
        check({tag, ".cnt_mispredicts"}, 64'(cnt_mispredicts), 64'(mp));
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        flush   = 1'b0;
        cnt_clr = 1'b0;
        bus.out_ready = 1'b0;
        drive(BR_NONE, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        bus.in_valid = 1'b0;

        // Reset state
        #12;
        check("rst.out_valid",  64'(bus.out_valid),      64'd0);
        check("rst.in_ready",   64'(bus.in_ready),       64'd1);
        check("rst.taken",      64'(bus.out_taken),      64'd0);
        check("rst.next_pc",    64'(bus.out_next_pc),    64'd0);
        check("rst.mispredict", 64'(bus.out_mispredict), 64'd0);
        check("rst.misaligned", 64'(bus.out_misaligned), 64'd0);
        check_cnt("rst", 4'd0, 4'd0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;

        // Back-to-back stream, one per cycle
        drive(BR_LT, 1'b0, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 1'b0, 32'h0);
        tick();
        check_out("lt", 1'b1, 32'h120, 1'b1, 1'b0);
        drive(BR_LTU, 1'b0, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 1'b0, 32'h0);
        tick();
        check_out("ltu", 1'b0, 32'h104, 1'b0, 1'b0);
        check_cnt("ltu", 4'd1, 4'd1);
        drive(BR_UNCOND, 1'b1, 32'h300, 32'h203, 32'h0, 32'h0, 1'b1, 32'h202);
        tick();
        check_out("jalr", 1'b1, 32'h202, 1'b0, 1'b1);
        check_cnt("jalr", 4'd2, 4'd1);
        // PC wrap-around, direction right but target wrong
        drive(BR_EQ, 1'b0, 32'hFFFF_FFFC, 32'h5, 32'h5, 32'h8, 1'b1, 32'h8);
        tick();
        check_out("eq_wrap", 1'b1, 32'h4, 1'b1, 1'b0);
        check_cnt("eq_wrap", 4'd3, 4'd1);
        // Signed >= on equal negatives, negative offset
        drive(BR_GE, 1'b0, 32'h400, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF8, 1'b1, 32'h3F8);
        tick();
        check_out("ge", 1'b1, 32'h3F8, 1'b0, 1'b0);
        check_cnt("ge", 4'd4, 4'd2);
        // Undefined encoding: never taken
        drive(branch_type_e'(4'hF), 1'b0, 32'h500, 32'h0, 32'h0, 32'h40, 1'b1, 32'h540);
        tick();
        check_out("undef", 1'b0, 32'h504, 1'b1, 1'b0);
        check_cnt("undef", 4'd5, 4'd2);
        drive(BR_NONE, 1'b0, 32'h600, 32'h0, 32'h0, 32'h40, 1'b0, 32'h0);
        tick();
        check_out("none", 1'b0, 32'h604, 1'b0, 1'b0);
        check_cnt("none", 4'd6, 4'd3);
        bus.in_valid = 1'b0;
        tick();
        check("idle.out_valid", 64'(bus.out_valid), 64'd0);
        check_cnt("idle", 4'd6, 4'd3);

        // Backpressure: two accepted, third held off
        bus.out_ready = 1'b0;
        drive(BR_NE, 1'b0, 32'h1000, 32'h1, 32'h2, 32'h10, 1'b1, 32'h1010);
        tick();
        check("bp1.in_ready", 64'(bus.in_ready), 64'd1);
        check_out("bp1", 1'b1, 32'h1010, 1'b0, 1'b0);
        drive(BR_NE, 1'b0, 32'h2000, 32'h7, 32'h7, 32'h10, 1'b0, 32'h0);
        tick();
        check("bp2.in_ready", 64'(bus.in_ready), 64'd0);
        check_out("bp2", 1'b1, 32'h1010, 1'b0, 1'b0);
        drive(BR_GEU, 1'b0, 32'h3000, 32'h1, 32'h2, 32'h10, 1'b1, 32'h3010);
        tick();
        check("bp3.in_ready", 64'(bus.in_ready), 64'd0);
        check_out("bp3_hold", 1'b1, 32'h1010, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        check("bp4.in_ready", 64'(bus.in_ready), 64'd1);
        check_out("bp4", 1'b0, 32'h2004, 1'b0, 1'b0);
        tick();
        check_out("bp5", 1'b0, 32'h3004, 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        tick();
        check("bp6.out_valid", 64'(bus.out_valid), 64'd0);
        check_cnt("bp6", 4'd9, 4'd4);

        // Flush with a full buffer, then with an incoming request
        bus.out_ready = 1'b0;
        drive(BR_EQ, 1'b0, 32'h4000, 32'h1, 32'h1, 32'h4, 1'b1, 32'h4004);
        tick();
        tick();
        check("fl.full_in_ready", 64'(bus.in_ready), 64'd0);
        flush = 1'b1;
        tick();
        check("fl1.out_valid", 64'(bus.out_valid), 64'd0);
        check("fl1.in_ready",  64'(bus.in_ready),  64'd1);
        bus.out_ready = 1'b1;
        tick();
        check("fl2.out_valid", 64'(bus.out_valid), 64'd0);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("fl3.out_valid", 64'(bus.out_valid), 64'd0);
        check_cnt("fl3", 4'd9, 4'd4);

        // Counter clear and saturation
        cnt_clr = 1'b1;
        tick();
        check_cnt("clr", 4'd0, 4'd0);
        cnt_clr = 1'b0;
        drive(BR_EQ, 1'b0, 32'h5000, 32'h3, 32'h3, 32'h10, 1'b1, 32'h5010);
        for (int i = 0; i < 20; i++) tick();
        bus.in_valid = 1'b0;
        tick();
        check_cnt("sat", 4'd15, 4'd0);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        cnt_clr = 1'b1;
        tick();
        check("clr_hs.out_valid", 64'(bus.out_valid), 64'd0);
        check_cnt("clr_hs", 4'd0, 4'd0);
        cnt_clr = 1'b0;

        // Asynchronous reset with both entries held
        bus.out_ready = 1'b0;
        drive(BR_UNCOND, 1'b0, 32'h6000, 32'h0, 32'h0, 32'h8, 1'b0, 32'h0);
        tick();
        tick();
        bus.in_valid = 1'b0;
        check("ar.pre_in_ready", 64'(bus.in_ready), 64'd0);
        check("ar.pre_taken",    64'(bus.out_taken), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar.out_valid", 64'(bus.out_valid),   64'd0);
        check("ar.in_ready",  64'(bus.in_ready),    64'd1);
        check("ar.taken",     64'(bus.out_taken),   64'd0);
        check("ar.next_pc",   64'(bus.out_next_pc), 64'd0);
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
